// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MIPS memory opcodes, FSM states, access sizes.
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load(op) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane extract/extend for loads and byte/half merge for read-modify-write stores.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic        sext_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] merged_o
);

  logic [4:0]  bsh, hsh;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] bmask, hmask;

  // Lane 0 is the most significant byte, so the shift is (3 - off) bytes.
  assign bsh   = {~off_i, 3'b000};
  assign hsh   = {~off_i[1], 4'b0000};
  assign bsel  = 8'(rdata_i >> bsh);
  assign hsel  = 16'(rdata_i >> hsh);
  assign bmask = 32'h0000_00ff << bsh;
  assign hmask = 32'h0000_ffff << hsh;

  always_comb begin
    ldata_o  = rdata_i;
    merged_o = wdata_i;
    case (size_i)
      SZ_B: begin
        ldata_o  = {{24{sext_i & bsel[7]}}, bsel};
        merged_o = (rdata_i & ~bmask) | ((wdata_i & 32'h0000_00ff) << bsh);
      end
      SZ_H: begin
        ldata_o  = {{16{sext_i & hsel[15]}}, hsel};
        merged_o = (rdata_i & ~hmask) | ((wdata_i & 32'h0000_ffff) << hsh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: one outstanding word transaction, RMW for sb/sh, one-cycle response.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and flag resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_wr_num,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_wr_num,
  output logic              resp_wr_en,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  size_e             size_q, size_d;
  logic              sext_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [4:0]        wr_num_q;
  logic              flushed_q;
  logic              mem_req_q, mem_rd_wr_q;
  logic [ADDR_W-1:0] mem_addr_q, addr_d;
  logic [31:0]       mem_wdata_q;
  logic              resp_valid_q, resp_wr_en_q;
  logic [31:0]       resp_rdata_q;
  logic [31:0]       ldata, merged;

  assign size_d = op_size(req_opcode);

  // Natural alignment; trapped accesses never reach memory, so clearing is harmless there.
  always_comb begin
    addr_d = req_addr;
    case (size_d)
      SZ_H:    addr_d[0]   = 1'b0;
      SZ_W:    addr_d[1:0] = 2'b00;
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_err_q, misalign_d;
  assign misalign_d = ((size_d == SZ_H) && req_addr[0]) ||
                      ((size_d == SZ_W) && (req_addr[1:0] != 2'b00));
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

  lsu_align u_align (
    .size_i  (size_q),
    .sext_i  (sext_q),
    .off_i   (off_q),
    .rdata_i (mem_rdata),
    .wdata_i (wdata_q),
    .ldata_o (ldata),
    .merged_o(merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= SZ_B;
      sext_q       <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      wr_num_q     <= '0;
      flushed_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_rd_wr_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_wr_en_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_wr_en_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid && is_mem_op(req_opcode)) begin
            size_q      <= size_d;
            sext_q      <= (req_opcode == OP_LB) || (req_opcode == OP_LH);
            off_q       <= addr_d[1:0];
            wdata_q     <= req_wdata;
            wr_num_q    <= req_wr_num;
            flushed_q   <= 1'b0;
            mem_addr_q  <= {addr_d[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else
`endif
            if (is_load(req_opcode)) begin
              state_q     <= RD;
              mem_req_q   <= 1'b1;
              mem_rd_wr_q <= 1'b1;
            end else if (req_opcode == OP_SW) begin
              state_q     <= WR;
              mem_req_q   <= 1'b1;
              mem_rd_wr_q <= 1'b0;
            end else begin
              state_q     <= RMW_RD;
              mem_req_q   <= 1'b1;
              mem_rd_wr_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_ack) begin
            state_q      <= RESP;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ldata;
            resp_wr_en_q <= ~(flushed_q | flush);
          end
        end
        RMW_RD: begin
          if (mem_ack) begin
            state_q     <= RMW_WR;
            mem_rd_wr_q <= 1'b0;
            mem_wdata_q <= merged;
          end
        end
        WR, RMW_WR: begin
          if (mem_ack) begin
            state_q      <= RESP;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign stall       = (state_q != IDLE);
  assign mem_req     = mem_req_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_wr_num = wr_num_q;
  // A flush seen during RESP still has to kill the writeback of this load.
  assign resp_wr_en  = resp_wr_en_q & ~flush;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a small acking memory model.
module tb_load_store_unit;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2b;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_wr_num = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_wr_num;
  logic        resp_wr_en, resp_err, stall;
  logic        mem_req, mem_rd_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wr_num(req_wr_num),
    .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_wr_num(resp_wr_num),
    .resp_wr_en(resp_wr_en), .resp_err(resp_err), .stall(stall),
    .mem_req(mem_req), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory model: acks after ack_delay waiting cycles, logs transactions, checks hold stability.
  int          ack_delay = 0;
  int          cnt = 0;
  logic [31:0] mem_word = '0;
  int          n_rd = 0, n_wr = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic        pend = 1'b0;
  logic [64:0] prev_bus = '0;

  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      cnt = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        total++;
        if ({mem_rd_wr, mem_addr, mem_wdata} !== prev_bus) begin
          bad++;
          $display("FAIL bus_stable: got %h want %h", {mem_rd_wr, mem_addr, mem_wdata}, prev_bus);
        end
      end
      if (cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem_word;
        if (mem_rd_wr) begin
          n_rd++;
          last_rd_addr = mem_addr;
        end else begin
          n_wr++;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
        end
        cnt = 0;
        pend = 1'b0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
        pend = 1'b1;
        prev_bus = {mem_rd_wr, mem_addr, mem_wdata};
      end
    end
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic        is_st;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mdata;
    int          exp_cyc;
  } vec_t;

  vec_t vt[11];

  // Present a request at a negedge; returns once the accepting edge has passed.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] tag);
    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = a;
    req_wdata  = wd;
    req_wr_num = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Edges after the accepting edge until resp_valid; cycle number = edges + 2.
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input int i);
    int n, rd0, wr0;
    vec_t v;
    v = vt[i];
    mem_word = v.mword;
    rd0 = n_rd;
    wr0 = n_wr;
    issue(v.op, v.addr, v.wdata, 5'(i + 1));
    chk($sformatf("v%0d_stall", i), 32'(stall), 32'd1);
    wait_resp(n);
    chk($sformatf("v%0d_cycles", i), n + 2, v.exp_cyc);
    chk($sformatf("v%0d_rdata", i), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_wr_en", i), 32'(resp_wr_en), 32'(v.exp_we));
    chk($sformatf("v%0d_err", i), 32'(resp_err), 32'd0);
    chk($sformatf("v%0d_tag", i), 32'(resp_wr_num), 32'(i + 1));
    if (v.is_st) begin
      chk($sformatf("v%0d_nwr", i), n_wr - wr0, 1);
      chk($sformatf("v%0d_nrd", i), n_rd - rd0, (v.exp_cyc == 4) ? 1 : 0);
      chk($sformatf("v%0d_waddr", i), last_wr_addr, v.exp_maddr);
      chk($sformatf("v%0d_wdata", i), last_wr_data, v.exp_mdata);
    end else begin
      chk($sformatf("v%0d_nrd", i), n_rd - rd0, 1);
      chk($sformatf("v%0d_nwr", i), n_wr - wr0, 0);
      chk($sformatf("v%0d_raddr", i), last_rd_addr, v.exp_maddr);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse", i), 32'(resp_valid), 32'd0);
    chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, rd0, wr0;
    //          op   addr         wdata        mem word     rdata        we    st    maddr        mdata        cyc
    vt[0]  = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[1]  = '{LB,  32'h103, 32'h0,        32'h000000F0, 32'hFFFFFFF0, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[2]  = '{LBU, 32'h103, 32'h0,        32'h000000F0, 32'h000000F0, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[3]  = '{LB,  32'h100, 32'h0,        32'h7F123456, 32'h0000007F, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[4]  = '{LB,  32'h101, 32'h0,        32'h11AA3344, 32'hFFFFFFAA, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[5]  = '{LH,  32'h102, 32'h0,        32'h12348001, 32'hFFFF8001, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[6]  = '{LH,  32'h100, 32'h0,        32'h12348001, 32'h00001234, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[7]  = '{LHU, 32'h102, 32'h0,        32'h12348001, 32'h00008001, 1'b1, 1'b0, 32'h100, 32'h0,        3};
    vt[8]  = '{SW,  32'h300, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 3};
    vt[9]  = '{SB,  32'h201, 32'h000000AB, 32'h11223344, 32'h0,        1'b0, 1'b1, 32'h200, 32'h11AB3344, 4};
    vt[10] = '{SH,  32'h202, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b0, 1'b1, 32'h200, 32'h1122BEEF, 4};

    // Reset state
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_wr_en", 32'(resp_wr_en), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i);

    // Non-memory opcode is ignored
    issue(6'h0F, 32'h100, 32'h0, 5'd1);
    chk("nop_stall", 32'(stall), 32'd0);
    chk("nop_mem_req", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("nop_no_resp", 32'(resp_valid), 32'd0);

    // lh with 5-cycle ack delay, second request held pending on req_valid
    ack_delay = 5;
    mem_word  = 32'h7FFF8001;
    issue(LH, 32'h102, 32'h0, 5'd7);
    req_valid  = 1'b1;
    req_opcode = LW;
    req_addr   = 32'h400;
    req_wr_num = 5'd9;
    n = 0;
    while (!resp_valid && n < 20) begin
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk("delay_edges", n, 6);
    chk("delay_rdata", resp_rdata, 32'hFFFF8001);
    chk("delay_tag", 32'(resp_wr_num), 32'd7);
    chk("resp_ready", 32'(req_ready), 32'd0);
    ack_delay = 0;
    mem_word  = 32'h12345678;
    @(posedge clk); #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("second_mem_req", 32'(mem_req), 32'd1);
    chk("second_addr", mem_addr, 32'h400);
    wait_resp(n);
    chk("second_rdata", resp_rdata, 32'h12345678);
    chk("second_tag", 32'(resp_wr_num), 32'd9);
    @(posedge clk); #1;

    // flush during RD
    mem_word = 32'hA5A5A5A5;
    rd0 = n_rd;
    issue(LW, 32'h104, 32'h0, 5'd3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flrd_valid", 32'(resp_valid), 32'd1);
    chk("flrd_wr_en", 32'(resp_wr_en), 32'd0);
    chk("flrd_nrd", n_rd - rd0, 1);
    @(posedge clk); #1;

    // flush during RESP
    issue(LW, 32'h108, 32'h0, 5'd4);
    @(posedge clk); #1;
    chk("flresp_wr_en_pre", 32'(resp_wr_en), 32'd1);
    flush = 1'b1;
    #1;
    chk("flresp_wr_en", 32'(resp_wr_en), 32'd0);
    chk("flresp_valid", 32'(resp_valid), 32'd1);
    flush = 1'b0;
    @(posedge clk); #1;

    // flush does not cancel a store
    wr0 = n_wr;
    flush = 1'b1;
    issue(SW, 32'h50, 32'h01020304, 5'd5);
    wait_resp(n);
    flush = 1'b0;
    chk("flst_valid", 32'(resp_valid), 32'd1);
    chk("flst_nwr", n_wr - wr0, 1);
    chk("flst_wdata", last_wr_data, 32'h01020304);
    @(posedge clk); #1;

    // reset during RMW_WR
    mem_word = 32'h11223344;
    wr0 = n_wr;
    issue(SB, 32'h201, 32'hAB, 5'd6);
    @(posedge clk); #1;
    ack_delay = 50;
    chk("rmw_wr_req", 32'(mem_req), 32'd1);
    chk("rmw_wr_dir", 32'(mem_rd_wr), 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_delay = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("arst_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("arst_nwr", n_wr - wr0, 0);
    chk("arst_ready", 32'(req_ready), 32'd1);

    // Misaligned lw at 0x102
    mem_word = 32'h0BADF00D;
    rd0 = n_rd;
    issue(LW, 32'h102, 32'h0, 5'd2);
    wait_resp(n);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_cycles", n + 2, 2);
    chk("mis_err", 32'(resp_err), 32'd1);
    chk("mis_wr_en", 32'(resp_wr_en), 32'd0);
    chk("mis_nrd", n_rd - rd0, 0);
`else
    chk("mis_cycles", n + 2, 3);
    chk("mis_err", 32'(resp_err), 32'd0);
    chk("mis_rdata", resp_rdata, 32'h0BADF00D);
    chk("mis_nrd", n_rd - rd0, 1);
    chk("mis_raddr", last_rd_addr, 32'h100);
`endif
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 clk  input  1  single clock for all state; rising edge active.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 req_valid  input  1  pipeline (EX/MM) presents a memory operation.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_opcode  input  6  MIPS opcode: lb, lbu, lh, lhu, lw, sb, sh or sw.
REQ-007 req_addr  input  ADDR_W  effective byte address computed by the ALU.
REQ-008 req_wdata  input  32  store data, right-justified.
REQ-009 req_wr_num  input  5  load destination register, returned with the response.
REQ-010 flush  input  1  suppresses the response of an in-flight load.
REQ-011 resp_valid  output  1  one-cycle pulse when an operation completes.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores.
REQ-013 resp_wr_num  output  5  register tag of the completed operation.
REQ-014 resp_wr_en  output  1  high with resp_valid for unflushed loads only.
REQ-015 resp_err  output  1  misalignment flag, qualified by resp_valid.
REQ-016 stall  output  1  high whenever the unit is not IDLE.
REQ-017 mem_req  output  1  word transaction request, held until mem_ack.
REQ-018 mem_rd_wr  output  1  1 = read, 0 = write.
REQ-019 mem_addr  output  ADDR_W  word-aligned address; bits [1:0] are 0.
REQ-020 mem_wdata  output  32  write word.
REQ-021 mem_ack  input  1  one-cycle completion pulse; read data is valid in the same cycle.
REQ-022 mem_rdata  input  32  read word.

Function
REQ-023 States SHALL be IDLE, RD, WR, RMW_RD, RMW_WR, RESP; req_ready = (state == IDLE).
REQ-024 A handshake (req_valid && req_ready) SHALL register opcode, addr, wdata and wr_num; non-memory opcodes SHALL be ignored, with no state change.
REQ-025 Transitions from IDLE: loads SHALL go to RD, sw to WR, sb and sh to RMW_RD.
REQ-026 mem_req SHALL assert from the cycle after acceptance, and all mem_* outputs SHALL stay stable until mem_ack.
REQ-027 On mem_ack: RD SHALL go to RESP, latching the extracted data; WR and RMW_WR SHALL go to RESP; RMW_RD SHALL go to RMW_WR, with the new byte or half merged into mem_rdata.
REQ-028 RESP SHALL last exactly one cycle, drive resp_valid = 1, then return to IDLE.
REQ-029 A load SHALL take a minimum of 3 cycles from acceptance to resp_valid, assuming mem_ack in the first mem_req cycle; sw SHALL take 3; sb and sh SHALL take 4.
REQ-030 Lane order SHALL be big-endian: addr[1:0] = 0 selects bits [31:24]; a half-word at addr[1] = 0 is bits [31:16].
REQ-031 lb and lh SHALL sign-extend to 32 bits; lbu and lhu SHALL zero-extend.
REQ-032 flush during RD or RESP of a load SHALL still complete the bus transaction but force resp_wr_en = 0; flush SHALL NOT affect stores.
REQ-033 A mem_ack arriving outside RD, WR, RMW_RD or RMW_WR SHALL be ignored.

Reset
REQ-034 On reset: state = IDLE, mem_req = 0, resp_valid = 0, resp_wr_en = 0, resp_err = 0, stall = 0, and all data and address registers = 0.
REQ-035 Reset mid-transaction SHALL drop mem_req asynchronously and abandon the operation, producing no response.

Configuration
REQ-036 With macro LSU_MISALIGN_TRAP_EN defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL skip memory and go directly to RESP with resp_err = 1 and resp_wr_en = 0.
REQ-037 Without LSU_MISALIGN_TRAP_EN, the low address bits SHALL be silently cleared to natural alignment, and resp_err SHALL be tied to 0.

Structure
REQ-038 Package lsu_pkg SHALL hold the memory opcode constants, the state enum and the access-size typedef.
REQ-039 Combinational lane extract, extend and merge logic SHALL live in sub-module lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-040 lw at 0x100 with mem_rdata = 0xDEADBEEF and ack on the first cycle -> resp_valid 3 cycles after accept, resp_rdata = 0xDEADBEEF, resp_wr_en = 1.
REQ-041 lb at 0x103 with mem_rdata = 0x000000F0 -> resp_rdata = 0xFFFFFFF0; the same access with lbu -> 0x000000F0.
REQ-042 sb 0xAB at 0x201 with old word 0x11223344 -> read then write of 0x11AB3344 at 0x200, resp_valid at cycle 4.
REQ-043 mem_ack delayed 5 cycles during lh, with req_valid held high -> req_ready = 0 and stall = 1 throughout, mem_* outputs stable, second request accepted only after RESP.
REQ-044 flush asserted during RD of lw -> one mem transaction, resp_valid = 1, resp_wr_en = 0; reset asserted during RMW_WR -> mem_req = 0 at once, no resp_valid.
REQ-045 lw at 0x102: with LSU_MISALIGN_TRAP_EN -> resp_err = 1 and no mem_req; without it -> read of 0x100, resp_err = 0.
